// File: rtl/chip8_timer_unit.sv
// rtl/chip8_timer_unit.sv - CHIP-8 delay/sound timers, 60 Hz prescaler, buzzer tone generator
// Optional feature macro: TIMER_FREEZE_EN (adds a freeze input that halts prescaler, timers and tone)
module chip8_timer_unit #(
  parameter int CLK_HZ  = 50_000_000,
  parameter int TICK_HZ = 60,
  parameter int TONE_HZ = 440
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wr_en,
  input  logic       wr_sel,
  input  logic [7:0] wr_data,
  input  logic       rd_req,
`ifdef TIMER_FREEZE_EN
  input  logic       freeze,
`endif
  output logic [7:0] rd_data,
  output logic       rd_valid,
  output logic       tick_60,
  output logic       delay_zero,
  output logic       sound_active,
  output logic       buzzer
);

  // Divider values clamped so degenerate parameter choices still give a working counter
  localparam int TICK_DIV_RAW = CLK_HZ / TICK_HZ;
  localparam int TICK_DIV     = (TICK_DIV_RAW < 1) ? 1 : TICK_DIV_RAW;
  localparam int TONE_DIV     = CLK_HZ / TONE_HZ;
  localparam int HALF_RAW     = TONE_DIV / 2;
  localparam int HALF         = (HALF_RAW < 1) ? 1 : HALF_RAW;
  localparam int PW           = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int CW           = $clog2(HALF + 1);

  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [CW-1:0] TONE_LAST  = CW'(HALF - 1);

  typedef enum logic [1:0] {
    TONE_IDLE = 2'd0,
    TONE_HIGH = 2'd1,
    TONE_LOW  = 2'd2
  } tone_state_t;

  logic [PW-1:0] presc;
  logic [7:0]    dt;
  logic [7:0]    st;
  logic [CW-1:0] tone_cnt;
  tone_state_t   tone_state;
  logic          hold;
  logic          dec;

`ifdef TIMER_FREEZE_EN
  assign hold = freeze;
`else
  assign hold = 1'b0;
`endif

  // A tick decrements the timers only when the unit is not frozen
  assign dec          = tick_60 & ~hold;
  assign delay_zero   = (dt == 8'd0);
  assign sound_active = (st != 8'd0);

  // Prescaler: 0..TICK_DIV-1; tick_60 is the registered terminal-count strobe
  always_ff @(posedge clk) begin
    if (!reset) begin
      presc   <= '0;
      tick_60 <= 1'b0;
    end else if (hold) begin
      tick_60 <= 1'b0;
    end else begin
      tick_60 <= (presc == PRESC_LAST);
      presc   <= (presc == PRESC_LAST) ? '0 : presc + PW'(1);
    end
  end

  // Delay timer: a write wins over a same-cycle decrement; saturates at zero
  always_ff @(posedge clk) begin
    if (!reset) begin
      dt <= 8'd0;
    end else if (wr_en && !wr_sel) begin
      dt <= wr_data;
    end else if (dec && dt != 8'd0) begin
      dt <= dt - 8'd1;
    end
  end

  // Sound timer: same rules as the delay timer, selected by wr_sel=1
  always_ff @(posedge clk) begin
    if (!reset) begin
      st <= 8'd0;
    end else if (wr_en && wr_sel) begin
      st <= wr_data;
    end else if (dec && st != 8'd0) begin
      st <= st - 8'd1;
    end
  end

  // Read port: capture DT as held in the request cycle, valid one cycle later
  always_ff @(posedge clk) begin
    if (!reset) begin
      rd_data  <= 8'd0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_req;
      if (rd_req) begin
        rd_data <= dt;
      end
    end
  end

  // Tone FSM: square wave with HALF-cycle phases while ST is nonzero
  always_ff @(posedge clk) begin
    if (!reset) begin
      tone_state <= TONE_IDLE;
      tone_cnt   <= '0;
      buzzer     <= 1'b0;
    end else if (hold || st == 8'd0) begin
      tone_state <= TONE_IDLE;
      tone_cnt   <= '0;
      buzzer     <= 1'b0;
    end else begin
      case (tone_state)
        TONE_IDLE: begin
          tone_state <= TONE_HIGH;
          tone_cnt   <= '0;
          buzzer     <= 1'b1;
        end
        TONE_HIGH: begin
          if (tone_cnt == TONE_LAST) begin
            tone_state <= TONE_LOW;
            tone_cnt   <= '0;
            buzzer     <= 1'b0;
          end else begin
            tone_cnt <= tone_cnt + CW'(1);
          end
        end
        TONE_LOW: begin
          if (tone_cnt == TONE_LAST) begin
            tone_state <= TONE_HIGH;
            tone_cnt   <= '0;
            buzzer     <= 1'b1;
          end else begin
            tone_cnt <= tone_cnt + CW'(1);
          end
        end
        default: begin
          tone_state <= TONE_IDLE;
          tone_cnt   <= '0;
          buzzer     <= 1'b0;
        end
      endcase
    end
  end

endmodule
